// File: rtl/jk_mod_counter.sv
// Synchronous modulo-N up/down counter built from per-bit JK cells.
// This block owns the J/K excitation, the RUN/HALT one-shot FSM, tc and the wrap pulse.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  typedef enum logic {RUN, HALT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] load_clamped;
  logic             carry;
  logic             at_term;
  logic             step;
  logic             wrap_q, wrap_d;

  always_comb begin
    load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX : load_val;
    at_term      = up ? (count_q == MAX) : (count_q == '0);
    step         = en & (state_q == RUN);

    // Binary up/down carry chain; at the boundary, toggle exactly the bits
    // that differ from the wrap target (0 going up, MAX going down).
    carry  = 1'b1;
    toggle = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      toggle[i] = carry;
      carry     = carry & (up ? count_q[i] : ~count_q[i]);
    end
    if (at_term) begin
      toggle = up ? count_q : (count_q ^ MAX);
    end

    j = '0;
    k = '0;
    if (load) begin
      j = load_clamped;
      k = ~load_clamped;
    end else if (step) begin
      j = toggle;
      k = toggle;
    end

    wrap_d = ~load & step & at_term;

    state_d = state_q;
    if (load) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (step && at_term && oneshot) state_d = HALT;
        HALT:    if (!oneshot) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // JK storage cells
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (reset) begin
        count_q[b] <= 1'b0;
      end else begin
        case ({j[b], k[b]})
          2'b10:   count_q[b] <= 1'b1;
          2'b01:   count_q[b] <= 1'b0;
          2'b11:   count_q[b] <= ~count_q[b];
          default: count_q[b] <= count_q[b];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign done  = (state_q == HALT);
  assign tc    = en & at_term & (state_q == RUN);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Randomized and directed bench for jk_mod_counter against an arithmetic reference model.
module tb_jk_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset, en, up, load, oneshot;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc, wrap, done;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_cnt;
  bit m_halt;
  bit m_wrap;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .oneshot  (oneshot),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_tc(input bit e, input bit u);
    if (!e || m_halt) return 1'b0;
    return u ? (m_cnt == M - 1) : (m_cnt == 0);
  endfunction

  task automatic model_step(input bit r, input bit e, input bit u, input bit l,
                            input int lv, input bit os);
    int lvm;
    lvm = lv % (1 << W);
    if (r) begin
      m_cnt = 0; m_wrap = 0; m_halt = 0;
    end else if (l) begin
      m_cnt  = (lvm >= M) ? M - 1 : lvm;
      m_wrap = 0;
      m_halt = 0;
    end else if (m_halt) begin
      m_wrap = 0;
      if (!os) m_halt = 0;
    end else if (e) begin
      if (u && m_cnt == M - 1) begin
        m_cnt = 0; m_wrap = 1; m_halt = os;
      end else if (!u && m_cnt == 0) begin
        m_cnt = M - 1; m_wrap = 1; m_halt = os;
      end else begin
        m_cnt  = u ? m_cnt + 1 : m_cnt - 1;
        m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  // Drive one cycle of inputs, compare all outputs to the model, then advance.
  task automatic cyc(input bit r, input bit e, input bit u, input bit l,
                     input int lv, input bit os);
    @(negedge clk);
    reset    = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv[W-1:0];
    oneshot  = os;
    #1;
    check("count", count, m_cnt);
    check("wrap",  wrap,  m_wrap);
    check("done",  done,  m_halt);
    check("tc",    tc,    model_tc(e, u));
    @(posedge clk);
    model_step(r, e, u, l, lv, os);
    #1;
  endtask

  initial begin
    bit r_up, r_os;
    reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0; oneshot = 1'b0;
    @(posedge clk);
    #1;
    m_cnt = 0; m_wrap = 0; m_halt = 0;
    check("rst_count", count, 0);
    check("rst_wrap",  wrap,  0);
    check("rst_done",  done,  0);

    // Free-run up through the wrap
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 0);
    check("up12_count", count, 2);

    // Load 3, count down across zero
    cyc(0, 0, 0, 1, 3, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
    check("dn5_count", count, 8);

    // Clamped load
    cyc(0, 0, 0, 1, 13, 0);
    check("clamp_count", count, 9);
    check("clamp_wrap",  wrap,  0);
    cyc(0, 0, 1, 1, 15, 0);
    check("clamp15_count", count, 9);

    // One-shot: 7,8,9,0 then halt
    cyc(0, 0, 1, 1, 7, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 1);
    check("os_count", count, 0);
    check("os_done",  done,  1);
    check("os_wrap",  wrap,  1);
    for (int i = 0; i < 3; i++) cyc(0, 1, i[0], 0, 0, 1);
    check("os_hold", count, 0);
    cyc(0, 1, 1, 1, 2, 1);
    check("os_reload_done", done, 0);
    cyc(0, 1, 1, 0, 0, 1);
    check("os_resume", count, 3);

    // Load at terminal count with en beats the wrap
    cyc(0, 0, 1, 1, 9, 1);
    cyc(0, 1, 1, 1, 4, 1);
    check("ldtc_count", count, 4);
    check("ldtc_wrap",  wrap,  0);
    check("ldtc_done",  done,  0);

    // Halt, then reset
    cyc(0, 0, 1, 1, 9, 1);
    cyc(0, 1, 1, 0, 0, 1);
    check("halt_done", done, 1);
    cyc(1, 1, 1, 1, 5, 1);
    check("rst_halt_count", count, 0);
    check("rst_halt_done",  done,  0);
    check("rst_halt_wrap",  wrap,  0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    check("rst_resume", count, 2);

    // Halt, then release by dropping oneshot
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    check("dn_halt_count", count, M - 1);
    cyc(0, 1, 0, 0, 0, 0);
    check("release_hold", count, M - 1);
    cyc(0, 1, 0, 0, 0, 0);
    check("release_step", count, M - 2);

    // Randomized traffic
    r_up = 1'b1;
    r_os = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0)  r_up = ~r_up;
      if ($urandom_range(0, 15) == 0) r_os = ~r_os;
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) != 0), r_up,
          ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)), r_os);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
